// File: rtl/executs_mdu.sv
// Multiply/divide unit with HI/LO registers.
// Sequential shift-add multiply and restoring divide, one iteration per cycle,
// followed by a sign-adjust cycle that commits HI/LO.
module executs_mdu #(
  parameter int DATA_W    = 32,
  parameter bit DIV0_FAST = 1'b1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic              flush,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              div_by_zero
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]       LAST_CNT = CW'(DATA_W - 1);
  localparam logic [CW-1:0]       ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0]   ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [2*DATA_W-1:0] ONE_2W   = {{(2*DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_ADJ  = 2'd3
  } state_e;

  // Two's-complement negation helpers for single and double width values.
  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v);
    return ~v + ONE_2W;
  endfunction

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, res_q, res_d;
  logic [DATA_W-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
  logic                neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic                is_div_q, is_div_d, dz_q, dz_d;
  logic                busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic                accept_s, sgn_s, a_neg_s, b_neg_s, b_zero_s;
  logic [DATA_W-1:0]   a_mag_s, b_mag_s;
  logic [DATA_W:0]     mul_sum_s, div_shift_s, div_trial_s;
  logic [2*DATA_W-1:0] prod_s;

  // Requests are only taken in IDLE, and a simultaneous flush drops them.
  assign accept_s    = start & ~flush & (state_q == S_IDLE);
  assign sgn_s       = ~op[0];
  assign a_neg_s     = sgn_s & a_in[DATA_W-1];
  assign b_neg_s     = sgn_s & b_in[DATA_W-1];
  assign a_mag_s     = a_neg_s ? neg_w(a_in) : a_in;
  assign b_mag_s     = b_neg_s ? neg_w(b_in) : b_in;
  assign b_zero_s    = (b_in == {DATA_W{1'b0}});
  // acc_hi/acc_lo hold partial product (multiply) or remainder/quotient (divide).
  assign mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});
  assign div_shift_s = {acc_hi_q, acc_lo_q[DATA_W-1]};
  assign div_trial_s = div_shift_s - {1'b0, opb_q};
  assign prod_s      = {acc_hi_q, acc_lo_q};

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s && !op[2]) begin
            if (op[1] && b_zero_s && DIV0_FAST) state_d = S_ADJ;
            else if (op[1])                     state_d = S_DIV;
            else                                state_d = S_MUL;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          if (cnt_q == LAST_CNT) state_d = S_ADJ;
          else                   state_d = state_q;
        end
        S_ADJ:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and output next values: operand capture, iterations, commit.
  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    busy_d   = (state_d != S_IDLE);
    if (flush) begin
      done_d = 1'b0;
      dbz_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                acc_hi_d = {DATA_W{1'b0}};
                acc_lo_d = a_mag_s;
                opb_d    = b_mag_s;
                cnt_d    = {CW{1'b0}};
                neg_lo_d = a_neg_s ^ b_neg_s;
                neg_hi_d = a_neg_s;
                is_div_d = op[1];
                dz_d     = op[1] & b_zero_s;
                if (op[1] && b_zero_s && DIV0_FAST) begin
                  done_d = 1'b1;
                  dbz_d  = 1'b1;
                end else begin
                  done_d = 1'b0;
                  dbz_d  = 1'b0;
                end
              end
              3'b100: begin res_d = hi_q; done_d = 1'b1; end
              3'b101: begin res_d = lo_q; done_d = 1'b1; end
              3'b110: begin hi_d  = a_in; done_d = 1'b1; end
              3'b111: begin lo_d  = a_in; done_d = 1'b1; end
              default: done_d = 1'b0;
            endcase
          end else begin
            done_d = 1'b0;
          end
        end
        S_MUL: begin
          acc_hi_d = mul_sum_s[DATA_W:1];
          acc_lo_d = {mul_sum_s[0], acc_lo_q[DATA_W-1:1]};
          cnt_d    = cnt_q + ONE_C;
        end
        S_DIV: begin
          if (!div_trial_s[DATA_W]) acc_hi_d = div_trial_s[DATA_W-1:0];
          else                      acc_hi_d = div_shift_s[DATA_W-1:0];
          acc_lo_d = {acc_lo_q[DATA_W-2:0], ~div_trial_s[DATA_W]};
          cnt_d    = cnt_q + ONE_C;
        end
        S_ADJ: begin
          if (dz_q) begin
            // Fast divide-by-zero already reported at acceptance.
            done_d = !DIV0_FAST;
            dbz_d  = !DIV0_FAST;
          end else if (is_div_q) begin
            lo_d   = neg_lo_q ? neg_w(acc_lo_q) : acc_lo_q;
            hi_d   = neg_hi_q ? neg_w(acc_hi_q) : acc_hi_q;
            done_d = 1'b1;
          end else begin
            {hi_d, lo_d} = neg_lo_q ? neg_2w(prod_s) : prod_s;
            done_d       = 1'b1;
          end
        end
        default: done_d = 1'b0;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {CW{1'b0}};
      hi_q     <= {DATA_W{1'b0}};
      lo_q     <= {DATA_W{1'b0}};
      res_q    <= {DATA_W{1'b0}};
      acc_hi_q <= {DATA_W{1'b0}};
      acc_lo_q <= {DATA_W{1'b0}};
      opb_q    <= {DATA_W{1'b0}};
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = res_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign div_by_zero = dbz_q;

endmodule
